// File: rtl/viterbi_frame_ctrl.sv
// viterbi_frame_ctrl
// Frame sequencer for the convolutional encoder / channel / Viterbi decoder
// loop. It pulls FRAME_LEN payload bits from a bit source and drives them into
// the encoder. It then appends TAIL_LEN zero bits to flush the trellis. Each
// encoder input is delayed by DEC_LAT clocks so it lines up with the matching
// decoded bit. The decoded payload bits are compared against that delayed copy,
// and a per-frame error count is reported together with a done pulse.
//
// Optional build macro: VIT_CTRL_RUNSTAT_EN
//   defined   - tracks the longest run of consecutive mismatches on max_run_o
//   undefined - max_run_o is tied to zero and no run logic exists
//
// Handshake: start_i is a request sampled only in IDLE. It is not queued.
// Asserting start_i while busy_o=1, including in the DONE cycle, has no effect.
// src_req_o=1 means src_bit_i is consumed at the end of this cycle. The source
// cannot stall. cap_valid_o=1 means dec_bit_i carries a decoded payload bit in
// this cycle. done_o is a single-cycle pulse, and err_ct_o / max_run_o are
// stable from that pulse until the next accepted start.
// state_dbg_o exposes the FSM state for checkers:
//   0 = IDLE, 1 = SEND, 2 = TAIL, 3 = DRAIN, 4 = DONE.

module viterbi_frame_ctrl #(
    parameter int FRAME_LEN = 256,
    parameter int TAIL_LEN  = 2,
    parameter int DEC_LAT   = 16,
    parameter int CW        = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    output logic          busy_o,
    output logic          src_req_o,
    input  logic          src_bit_i,
    output logic          enc_en_o,
    output logic          enc_bit_o,
    input  logic          dec_bit_i,
    output logic          cap_valid_o,
    output logic          cap_bit_o,
    output logic          done_o,
    output logic [CW-1:0] err_ct_o,
    output logic [7:0]    max_run_o,
    output logic [2:0]    state_dbg_o
);

    localparam int FW = $clog2(FRAME_LEN + 1);
    localparam int TW = (TAIL_LEN > 0) ? $clog2(TAIL_LEN + 1) : 1;

    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_LEN - 1);
    localparam logic [FW-1:0] FRAME_FULL = FW'(FRAME_LEN);
    localparam logic [TW-1:0] TAIL_LAST  = TW'((TAIL_LEN > 0) ? TAIL_LEN - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SEND  = 3'd1,
        S_TAIL  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic          start_acc;
    logic [FW-1:0] send_cnt;
    logic [TW-1:0] tail_cnt;
    logic [FW-1:0] cap_cnt;
    logic          cap_last;
    logic          enc_pay;
    logic [DEC_LAT-1:0] dly_tag;
    logic [DEC_LAT-1:0] dly_bit;
    logic          ref_bit;
    logic          mismatch;
    logic [CW-1:0] err_q;

    // Delayed reference bit and compare result for the current capture slot
    assign ref_bit  = dly_bit[DEC_LAT-1];
    assign mismatch = cap_valid_o & (dec_bit_i ^ ref_bit);

    // Frame is fully captured either already, or by the capture in this cycle.
    // The second term gives done_o exactly one cycle after the last capture.
    assign cap_last = (cap_cnt == FRAME_FULL) ||
                      (cap_valid_o && (cap_cnt == FRAME_LAST));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and start acceptance
    always_comb begin
        state_nxt = state;
        start_acc = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_i) begin
                    state_nxt = S_SEND;
                    start_acc = 1'b1;
                end
            end
            S_SEND: begin
                if (send_cnt == FRAME_LAST) begin
                    state_nxt = (TAIL_LEN == 0) ? S_DRAIN : S_TAIL;
                end
            end
            S_TAIL: begin
                if (tail_cnt == TAIL_LAST) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (cap_last) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State-decoded outputs and capture outputs
    always_comb begin
        busy_o      = (state != S_IDLE);
        src_req_o   = (state == S_SEND);
        done_o      = (state == S_DONE);
        cap_valid_o = dly_tag[DEC_LAT-1];
        cap_bit_o   = dec_bit_i & dly_tag[DEC_LAT-1];
        state_dbg_o = state;
    end

    // Encoder drive: payload in SEND, zeros with enable in TAIL, idle otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            enc_en_o  <= 1'b0;
            enc_bit_o <= 1'b0;
            enc_pay   <= 1'b0;
        end else begin
            case (state)
                S_SEND: begin
                    enc_en_o  <= 1'b1;
                    enc_bit_o <= src_bit_i;
                    enc_pay   <= 1'b1;
                end
                S_TAIL: begin
                    enc_en_o  <= 1'b1;
                    enc_bit_o <= 1'b0;
                    enc_pay   <= 1'b0;
                end
                default: begin
                    enc_en_o  <= 1'b0;
                    enc_bit_o <= 1'b0;
                    enc_pay   <= 1'b0;
                end
            endcase
        end
    end

    // Reference delay line: tag marks payload bits, so tail bits are never captured
    always_ff @(posedge clk) begin
        if (rst) begin
            dly_tag <= '0;
            dly_bit <= '0;
        end else begin
            dly_tag[0] <= enc_en_o & enc_pay;
            dly_bit[0] <= enc_bit_o;
            for (int i = 1; i < DEC_LAT; i++) begin
                dly_tag[i] <= dly_tag[i-1];
                dly_bit[i] <= dly_bit[i-1];
            end
        end
    end

    // Send, tail and capture counters, cleared when a frame starts
    always_ff @(posedge clk) begin
        if (rst || start_acc) begin
            send_cnt <= '0;
            tail_cnt <= '0;
            cap_cnt  <= '0;
        end else begin
            if (state == S_SEND) begin
                send_cnt <= send_cnt + 1'b1;
            end
            if (state == S_TAIL) begin
                tail_cnt <= tail_cnt + 1'b1;
            end
            if (cap_valid_o && (cap_cnt != FRAME_FULL)) begin
                cap_cnt <= cap_cnt + 1'b1;
            end
        end
    end

    // Saturating bit-error counter, held between frames
    always_ff @(posedge clk) begin
        if (rst || start_acc) begin
            err_q <= '0;
        end else if (mismatch && (err_q != {CW{1'b1}})) begin
            err_q <= err_q + 1'b1;
        end
    end

    assign err_ct_o = err_q;

`ifdef VIT_CTRL_RUNSTAT_EN
    logic [7:0] run_q;
    logic [7:0] run_nxt;
    logic [7:0] max_q;

    // Current mismatch run after this cycle's capture
    always_comb begin
        run_nxt = run_q;
        if (mismatch) begin
            run_nxt = (run_q == 8'hFF) ? run_q : run_q + 8'd1;
        end else if (cap_valid_o) begin
            run_nxt = 8'd0;
        end
    end

    // Run tracker and longest-run register, cleared when a frame starts
    always_ff @(posedge clk) begin
        if (rst || start_acc) begin
            run_q <= 8'd0;
            max_q <= 8'd0;
        end else if (cap_valid_o) begin
            run_q <= run_nxt;
            if (run_nxt > max_q) begin
                max_q <= run_nxt;
            end
        end
    end

    assign max_run_o = max_q;
`else
    assign max_run_o = 8'd0;
`endif

endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// Bench for viterbi_frame_ctrl: FRAME_LEN=8, TAIL_LEN=2, DEC_LAT=4, CW=3.
// A channel process plays the role of encoder+decoder. It is an ideal loop
// with a per-bit flip mask. Each frame's expected encoder bits, captured bits
// and end-of-frame counts are queued when the frame is issued. A negedge
// monitor pops those queues and compares them whenever the DUT presents
// output.

module tb_viterbi_frame_ctrl;

    localparam int F  = 8;
    localparam int T  = 2;
    localparam int D  = 4;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_i = 1'b0;
    logic          src_bit_i = 1'b0;
    logic          dec_bit_i = 1'b0;
    logic          busy_o;
    logic          src_req_o;
    logic          enc_en_o;
    logic          enc_bit_o;
    logic          cap_valid_o;
    logic          cap_bit_o;
    logic          done_o;
    logic [CW-1:0] err_ct_o;
    logic [7:0]    max_run_o;
    logic [2:0]    state_dbg_o;

    int vectors = 0;
    int miscompares = 0;

    // Scoreboard queues
    logic [0:0] exp_q[$];
    logic [0:0] exp_enc_q[$];
    typedef struct {
        int err;
        int run;
    } done_exp_t;
    done_exp_t exp_done_q[$];

    // Frame data shared with the channel process
    logic pay[F];
    logic flip[F];
    int   src_ptr = 0;
    int   enc_idx = 0;

    typedef struct {
        logic v;
        logic b;
        int   idx;
    } ch_t;
    ch_t  chan[D+1];
    logic req_seen;

    // Monitor bookkeeping
    int cyc = 0;
    int prev_busy = 0;
    int busy_rise = 0;
    int enc_n = 0;
    int cap_n = 0;
    int first_enc = -1;
    int first_cap = -1;
    int last_cap = -1;
    int gap = 0;
    int done_cyc = -10;
    int done_total = 0;

    viterbi_frame_ctrl #(
        .FRAME_LEN(F),
        .TAIL_LEN (T),
        .DEC_LAT  (D),
        .CW       (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .busy_o     (busy_o),
        .src_req_o  (src_req_o),
        .src_bit_i  (src_bit_i),
        .enc_en_o   (enc_en_o),
        .enc_bit_o  (enc_bit_o),
        .dec_bit_i  (dec_bit_i),
        .cap_valid_o(cap_valid_o),
        .cap_bit_o  (cap_bit_o),
        .done_o     (done_o),
        .err_ct_o   (err_ct_o),
        .max_run_o  (max_run_o),
        .state_dbg_o(state_dbg_o)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Source and ideal channel: a bit entering the encoder in cycle k
    // reaches dec_bit_i in cycle k+D, inverted where the flip mask says so
    initial begin
        for (int i = 0; i <= D; i++) chan[i] = '{v: 1'b0, b: 1'b0, idx: 0};
        for (int i = 0; i < F; i++) begin
            pay[i]  = 1'b0;
            flip[i] = 1'b0;
        end
    end

    always begin
        @(negedge clk);
        req_seen = src_req_o;
        @(posedge clk);
        #1;
        if (req_seen) src_ptr++;
        src_bit_i = (src_ptr < F) ? pay[src_ptr] : 1'b0;
        for (int i = D; i > 0; i--) chan[i] = chan[i-1];
        chan[0].v   = enc_en_o;
        chan[0].b   = enc_bit_o;
        chan[0].idx = enc_idx;
        if (enc_en_o) enc_idx++;
        if (chan[D].v && chan[D].idx < F)
            dec_bit_i = chan[D].b ^ flip[chan[D].idx];
        else
            dec_bit_i = chan[D].b;
    end

    // Monitor: pops expectations as the DUT presents encoder/capture/done output
    always @(negedge clk) begin
        cyc++;
        if (busy_o && prev_busy == 0) begin
            busy_rise = cyc;
            enc_n = 0;
            cap_n = 0;
            first_enc = -1;
            first_cap = -1;
            last_cap = -1;
            gap = 0;
        end
        if (enc_en_o) begin
            if (first_enc < 0) first_enc = cyc;
            enc_n++;
            if (exp_enc_q.size() == 0) begin
                check("enc_unexpected", 1, 0);
            end else begin
                check("enc_bit", enc_bit_o, exp_enc_q.pop_front());
            end
        end
        if (cap_valid_o) begin
            if (first_cap < 0) first_cap = cyc;
            if (last_cap >= 0 && last_cap != cyc - 1) gap = 1;
            last_cap = cyc;
            cap_n++;
            if (exp_q.size() == 0) begin
                check("cap_unexpected", 1, 0);
            end else begin
                check("cap_bit", cap_bit_o, exp_q.pop_front());
            end
        end else begin
            check("cap_bit_gated", cap_bit_o, 0);
        end
        if (done_o) begin
            done_total++;
            done_cyc = cyc;
            if (exp_done_q.size() == 0) begin
                check("done_unexpected", 1, 0);
            end else begin
                done_exp_t e;
                e = exp_done_q.pop_front();
                check("err_ct", err_ct_o, e.err);
                check("max_run", max_run_o, e.run);
                check("cap_count", cap_n, F);
                check("enc_count", enc_n, F + T);
                check("cap_contiguous", gap, 0);
                check("first_enc_lat", first_enc - busy_rise, 1);
                check("dec_lat", first_cap - first_enc, D);
                check("done_after_cap", cyc - last_cap, 1);
            end
        end
        if (cyc == done_cyc + 1) check("busy_drop", busy_o, 0);
        prev_busy = busy_o ? 1 : 0;
    end

    // Reference model for one frame's end-of-frame values
    function automatic done_exp_t model(input logic [F-1:0] fl);
        done_exp_t e;
        int errs = 0;
        int run = 0;
        int best = 0;
        for (int i = 0; i < F; i++) begin
            if (fl[i]) begin
                errs++;
                run++;
                if (run > best) best = run;
            end else begin
                run = 0;
            end
        end
        e.err = (errs > (2**CW - 1)) ? (2**CW - 1) : errs;
`ifdef VIT_CTRL_RUNSTAT_EN
        e.run = (best > 255) ? 255 : best;
`else
        e.run = 0;
`endif
        return e;
    endfunction

    // Load payload/flip mask and queue expectations; payload p is sent MSB first
    task automatic load_frame(input logic [F-1:0] p, input logic [F-1:0] fl, input bit with_caps);
        @(negedge clk);
        for (int i = 0; i < F; i++) begin
            pay[i]  = p[F-1-i];
            flip[i] = fl[i];
        end
        src_ptr = 0;
        enc_idx = 0;
        for (int i = 0; i < F; i++) exp_enc_q.push_back(pay[i]);
        for (int i = 0; i < T; i++) exp_enc_q.push_back(1'b0);
        if (with_caps) begin
            for (int i = 0; i < F; i++) exp_q.push_back(pay[i] ^ flip[i]);
            exp_done_q.push_back(model(fl));
        end
    endtask

    task automatic issue_start();
        @(posedge clk);
        #1 start_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
        check("err_clear_at_start", err_ct_o, 0);
        check("run_clear_at_start", max_run_o, 0);
        check("busy_after_start", busy_o, 1);
    endtask

    task automatic wait_done(output bit got);
        got = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (done_o) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check("done_timeout", 0, 1);
    endtask

    task automatic run_frame(input logic [F-1:0] p, input logic [F-1:0] fl, input bit poke_busy);
        bit        got;
        int        dt0;
        done_exp_t e;
        e = model(fl);
        load_frame(p, fl, 1'b1);
        issue_start();
        dt0 = done_total;
        if (poke_busy) begin
            for (int n = 0; n < 100; n++) begin
                @(negedge clk);
                if (busy_o && !src_req_o) break;
            end
            start_i = 1'b1;
            @(posedge clk);
            #1 start_i = 1'b0;
        end
        wait_done(got);
        if (got && poke_busy) begin
            start_i = 1'b1;
            @(posedge clk);
            #1 start_i = 1'b0;
        end
        repeat (8) @(negedge clk);
        check("err_hold_idle", err_ct_o, e.err);
        check("run_hold_idle", max_run_o, e.run);
        check("idle_after_frame", busy_o, 0);
        check("one_done_per_frame", done_total - dt0, 1);
    endtask

    task automatic reset_mid_frame();
        int n_req = 0;
        int dt0;
        load_frame(8'($urandom), 8'h00, 1'b0);
        issue_start();
        dt0 = done_total;
        for (int n = 0; n < 50 && n_req < 5; n++) begin
            @(negedge clk);
            if (src_req_o) n_req++;
        end
        rst = 1'b1;
        @(negedge clk);
        check("rst_outputs_zero",
              {busy_o, src_req_o, enc_en_o, enc_bit_o, cap_valid_o, cap_bit_o, done_o, err_ct_o, max_run_o}, 0);
        rst = 1'b0;
        exp_enc_q.delete();
        exp_q.delete();
        exp_done_q.delete();
        repeat (30) @(negedge clk);
        check("no_done_after_abort", done_total - dt0, 0);
        check("idle_after_abort", busy_o, 0);
    endtask

    // Stimulus sequence and final report
    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs_zero",
              {busy_o, src_req_o, enc_en_o, enc_bit_o, cap_valid_o, cap_bit_o, done_o, err_ct_o, max_run_o}, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_frame(8'b1011_0010, 8'b0000_0000, 1'b0);
        run_frame(8'b1011_0010, 8'b1001_1100, 1'b0);
        reset_mid_frame();
        run_frame(8'($urandom), 8'b0000_0000, 1'b0);
        run_frame(8'($urandom), 8'b1111_1111, 1'b0);
        run_frame(8'($urandom), 8'($urandom), 1'b1);
        for (int k = 0; k < 8; k++) begin
            run_frame(8'($urandom), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
        end

        check("exp_q_drained", exp_q.size(), 0);
        check("exp_enc_q_drained", exp_enc_q.size(), 0);
        check("exp_done_q_drained", exp_done_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
